// File: rtl/simmem_pkg.sv
// Shared types, defaults and helpers for the write-data matcher.
// The entry typedef is the default-width layout of one address-queue slot.
package simmem_pkg;

  localparam int unsigned DefaultAddrQueueDepth = 8;
  localparam int unsigned DefaultMaxEarlyBeats  = 64;
  localparam int unsigned DefaultBurstLenW      = 8;
  localparam int unsigned DefaultIidW           = 4;

  typedef struct packed {
    logic [DefaultIidW-1:0]    iid;
    logic [DefaultBurstLenW:0] remaining;
  } wdata_entry_t;

  // AXI encodes burst length as beats minus one.
  function automatic int unsigned eff_burst_len(input int unsigned len_field);
    return len_field + 1;
  endfunction

endpackage

// File: rtl/simmem_wdata_matcher_fifo.sv
// Address queue for the write-data matcher. The low CntW bits of each entry
// hold the remaining-beat count, which can be decremented in place at the head.
module simmem_wdata_matcher_fifo #(
  parameter int unsigned Depth  = 8,
  parameter int unsigned EntryW = 13,
  parameter int unsigned CntW   = 9
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [EntryW-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              dec_head_i,
  output logic [EntryW-1:0] head_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [EntryW-1:0] mem_q [Depth];
  logic [PtrW-1:0]   wptr_q;
  logic [PtrW-1:0]   rptr_q;
  logic [PtrW:0]     count_q;

  assign head_o  = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW+1)'(Depth));

  // Push never targets the head slot: it is blocked when full, and a decrement
  // only happens while the queue is non-empty, so wptr and rptr differ then.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (dec_head_i) begin
        mem_q[rptr_q][CntW-1:0] <= mem_q[rptr_q][CntW-1:0] - CntW'(1);
      end
      if (pop_i) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/simmem_wdata_matcher.sv
// Matches AXI write-data beats to queued write addresses, counting beats that
// arrive before their address and reporting completed bursts.
module simmem_wdata_matcher
  import simmem_pkg::*;
#(
  parameter int unsigned AddrQueueDepth = DefaultAddrQueueDepth,
  parameter int unsigned MaxEarlyBeats  = DefaultMaxEarlyBeats,
  parameter int unsigned BurstLenW      = DefaultBurstLenW,
  parameter int unsigned IidW           = DefaultIidW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 waddr_valid_i,
  output logic                 waddr_ready_o,
  input  logic [BurstLenW-1:0] waddr_burst_len_i,
  input  logic [IidW-1:0]      waddr_iid_i,
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  input  logic                 wdata_last_i,
  output logic                 core_waddr_valid_o,
  input  logic                 core_waddr_ready_i,
  output logic [IidW-1:0]      core_waddr_iid_o,
  output logic [BurstLenW:0]   core_wdata_immediate_cnt_o,
  output logic                 core_wdata_valid_o,
  output logic                 burst_done_valid_o,
  output logic [IidW-1:0]      burst_done_iid_o,
  output logic                 err_last_o
);

  localparam int unsigned CntW   = BurstLenW + 1;
  localparam int unsigned EarlyW = $clog2(MaxEarlyBeats + 1);
  localparam int unsigned EntryW = IidW + CntW;

  // Same layout as simmem_pkg::wdata_entry_t, sized by this instance.
  typedef struct packed {
    logic [IidW-1:0] iid;
    logic [CntW-1:0] remaining;
  } entry_t;

  entry_t            head;
  entry_t            push_entry;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              dec_head;
  logic              aw_fire;
  logic              w_fire;
  logic [31:0]       len_ext;
  logic [31:0]       avail_ext;
  logic [31:0]       imm_ext;

  logic [EarlyW-1:0] early_q, early_d;
  logic              done_valid_q, done_valid_d;
  logic [IidW-1:0]   done_iid_q, done_iid_d;
  logic              err_q, err_d;

  assign core_waddr_valid_o = waddr_valid_i & ~fifo_full;
  assign waddr_ready_o      = core_waddr_ready_i & ~fifo_full;
  assign core_waddr_iid_o   = waddr_iid_i;
  assign wdata_ready_o      = (early_q != EarlyW'(MaxEarlyBeats));

  assign aw_fire = waddr_valid_i & waddr_ready_o;
  assign w_fire  = wdata_valid_i & wdata_ready_o;

  // Early beats only exist while the queue is empty; otherwise nothing is
  // available to an arriving address and its whole length is queued.
  assign len_ext   = eff_burst_len(32'(waddr_burst_len_i));
  assign avail_ext = fifo_empty ? (32'(early_q) + 32'(w_fire)) : 32'd0;
  assign imm_ext   = (avail_ext < len_ext) ? avail_ext : len_ext;

  assign core_wdata_immediate_cnt_o = CntW'(imm_ext);

  always_comb begin
    early_d              = early_q;
    done_valid_d         = 1'b0;
    done_iid_d           = done_iid_q;
    err_d                = err_q;
    push                 = 1'b0;
    pop                  = 1'b0;
    dec_head             = 1'b0;
    core_wdata_valid_o   = 1'b0;
    push_entry.iid       = waddr_iid_i;
    push_entry.remaining = CntW'(len_ext - imm_ext);

    if (fifo_empty) begin
      early_d = EarlyW'(avail_ext - imm_ext);
      if (aw_fire) begin
        if (len_ext > imm_ext) begin
          push = 1'b1;
        end else begin
          done_valid_d = 1'b1;
          done_iid_d   = waddr_iid_i;
        end
      end else begin
        early_d = EarlyW'(avail_ext);
      end
    end else begin
      push = aw_fire;
      if (w_fire) begin
        core_wdata_valid_o = 1'b1;
        if (head.remaining == CntW'(1)) begin
          pop          = 1'b1;
          done_valid_d = 1'b1;
          done_iid_d   = head.iid;
          if (!wdata_last_i) err_d = 1'b1;
        end else begin
          dec_head = 1'b1;
          if (wdata_last_i) err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      early_q      <= '0;
      done_valid_q <= 1'b0;
      done_iid_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      early_q      <= early_d;
      done_valid_q <= done_valid_d;
      done_iid_q   <= done_iid_d;
      err_q        <= err_d;
    end
  end

  assign burst_done_valid_o = done_valid_q;
  assign burst_done_iid_o   = done_iid_q;
  assign err_last_o         = err_q;

  simmem_wdata_matcher_fifo #(
    .Depth  (AddrQueueDepth),
    .EntryW (EntryW),
    .CntW   (CntW)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .dec_head_i  (dec_head),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

endmodule

// File: tb/tb_simmem_wdata_matcher.sv
// Directed bench for the write-data matcher: a default-parameter instance and a
// small instance (depth 2, four early beats) sharing one stimulus set.
module tb_simmem_wdata_matcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       waddr_valid = 1'b0;
  logic [7:0] waddr_len = '0;
  logic [3:0] waddr_iid = '0;
  logic       wdata_valid = 1'b0;
  logic       wdata_last = 1'b0;
  logic       core_ready = 1'b1;

  logic       waddr_ready, wdata_ready, core_waddr_valid, core_wdata_valid;
  logic       done_valid, err_last;
  logic [3:0] core_iid, done_iid;
  logic [8:0] imm;

  logic       s_waddr_ready, s_wdata_ready, s_core_waddr_valid, s_core_wdata_valid;
  logic       s_done_valid, s_err_last;
  logic [3:0] s_core_iid, s_done_iid;
  logic [8:0] s_imm;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  simmem_wdata_matcher dut (
    .clk_i(clk), .rst_ni(rst_n),
    .waddr_valid_i(waddr_valid), .waddr_ready_o(waddr_ready),
    .waddr_burst_len_i(waddr_len), .waddr_iid_i(waddr_iid),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_last_i(wdata_last),
    .core_waddr_valid_o(core_waddr_valid), .core_waddr_ready_i(core_ready),
    .core_waddr_iid_o(core_iid), .core_wdata_immediate_cnt_o(imm),
    .core_wdata_valid_o(core_wdata_valid),
    .burst_done_valid_o(done_valid), .burst_done_iid_o(done_iid), .err_last_o(err_last)
  );

  simmem_wdata_matcher #(.AddrQueueDepth(2), .MaxEarlyBeats(4)) dut_s (
    .clk_i(clk), .rst_ni(rst_n),
    .waddr_valid_i(waddr_valid), .waddr_ready_o(s_waddr_ready),
    .waddr_burst_len_i(waddr_len), .waddr_iid_i(waddr_iid),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(s_wdata_ready), .wdata_last_i(wdata_last),
    .core_waddr_valid_o(s_core_waddr_valid), .core_waddr_ready_i(core_ready),
    .core_waddr_iid_o(s_core_iid), .core_wdata_immediate_cnt_o(s_imm),
    .core_wdata_valid_o(s_core_wdata_valid),
    .burst_done_valid_o(s_done_valid), .burst_done_iid_o(s_done_iid), .err_last_o(s_err_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    waddr_valid = 1'b0;
    wdata_valid = 1'b0;
    wdata_last  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic addr(input logic [7:0] len, input logic [3:0] iid);
    waddr_valid = 1'b1;
    waddr_len   = len;
    waddr_iid   = iid;
  endtask

  task automatic beat(input logic last);
    wdata_valid = 1'b1;
    wdata_last  = last;
  endtask

  task automatic test_reset();
    idle();
    core_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    tests_run++; if (done_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_done_valid: got %b expected 0", done_valid); end
    tests_run++; if (done_iid !== 4'd0) begin tests_failed++; $display("FAIL reset_done_iid: got %0d expected 0", done_iid); end
    tests_run++; if (err_last !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err_last); end
    tests_run++; if (wdata_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_wdata_ready: got %b expected 1", wdata_ready); end
    tests_run++; if (waddr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_waddr_ready_hi: got %b expected 1", waddr_ready); end
    core_ready = 1'b0;
    #1;
    tests_run++; if (waddr_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_waddr_ready_lo: got %b expected 0", waddr_ready); end
    core_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    addr(8'd3, 4'd5);
    #1;
    tests_run++; if (core_waddr_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_core_waddr_valid: got %b expected 1", core_waddr_valid); end
    tests_run++; if (core_iid !== 4'd5) begin tests_failed++; $display("FAIL basic_core_iid: got %0d expected 5", core_iid); end
    tests_run++; if (imm !== 9'd0) begin tests_failed++; $display("FAIL basic_imm: got %0d expected 0", imm); end
    step();
    idle();
    for (int i = 0; i < 4; i++) begin
      beat(i == 3);
      #1;
      tests_run++; if (core_wdata_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_fwd beat %0d: got %b expected 1", i, core_wdata_valid); end
      step();
      tests_run++; if (done_valid !== (i == 3)) begin tests_failed++; $display("FAIL basic_done beat %0d: got %b expected %b", i, done_valid, (i == 3)); end
    end
    idle();
    tests_run++; if (done_iid !== 4'd5) begin tests_failed++; $display("FAIL basic_done_iid: got %0d expected 5", done_iid); end
    step();
    tests_run++; if (done_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse: got %b expected 0", done_valid); end
    tests_run++; if (err_last !== 1'b0) begin tests_failed++; $display("FAIL basic_err: got %b expected 0", err_last); end
  endtask

  task automatic test_early();
    for (int i = 0; i < 6; i++) begin
      beat(1'b0);
      #1;
      tests_run++; if (core_wdata_valid !== 1'b0) begin tests_failed++; $display("FAIL early_no_fwd %0d: got %b expected 0", i, core_wdata_valid); end
      step();
    end
    idle();
    addr(8'd3, 4'd2);
    #1;
    tests_run++; if (imm !== 9'd4) begin tests_failed++; $display("FAIL early_imm4: got %0d expected 4", imm); end
    step();
    idle();
    tests_run++; if (done_valid !== 1'b1 || done_iid !== 4'd2) begin tests_failed++; $display("FAIL early_done_a: got %b/%0d expected 1/2", done_valid, done_iid); end
    addr(8'd1, 4'd3);
    #1;
    tests_run++; if (imm !== 9'd2) begin tests_failed++; $display("FAIL early_imm2: got %0d expected 2", imm); end
    step();
    idle();
    tests_run++; if (done_valid !== 1'b1 || done_iid !== 4'd3) begin tests_failed++; $display("FAIL early_done_b: got %b/%0d expected 1/3", done_valid, done_iid); end
    addr(8'd0, 4'd4);
    #1;
    tests_run++; if (imm !== 9'd0) begin tests_failed++; $display("FAIL early_drained_imm: got %0d expected 0", imm); end
    step();
    idle();
    tests_run++; if (done_valid !== 1'b0) begin tests_failed++; $display("FAIL early_queued: got %b expected 0", done_valid); end
    beat(1'b1);
    #1;
    tests_run++; if (core_wdata_valid !== 1'b1) begin tests_failed++; $display("FAIL early_fwd: got %b expected 1", core_wdata_valid); end
    step();
    idle();
    tests_run++; if (done_valid !== 1'b1 || done_iid !== 4'd4) begin tests_failed++; $display("FAIL early_done_c: got %b/%0d expected 1/4", done_valid, done_iid); end
    tests_run++; if (err_last !== 1'b0) begin tests_failed++; $display("FAIL early_err: got %b expected 0", err_last); end
    step();
  endtask

  task automatic test_same_cycle();
    addr(8'd0, 4'd6);
    beat(1'b1);
    #1;
    tests_run++; if (imm !== 9'd1) begin tests_failed++; $display("FAIL same_imm: got %0d expected 1", imm); end
    tests_run++; if (core_wdata_valid !== 1'b0) begin tests_failed++; $display("FAIL same_no_fwd: got %b expected 0", core_wdata_valid); end
    step();
    idle();
    tests_run++; if (done_valid !== 1'b1 || done_iid !== 4'd6) begin tests_failed++; $display("FAIL same_done: got %b/%0d expected 1/6", done_valid, done_iid); end
    addr(8'd0, 4'd7);
    #1;
    tests_run++; if (imm !== 9'd0) begin tests_failed++; $display("FAIL same_early_zero: got %0d expected 0", imm); end
    step();
    idle();
    beat(1'b1);
    step();
    idle();
    tests_run++; if (done_valid !== 1'b1 || done_iid !== 4'd7) begin tests_failed++; $display("FAIL same_done_b: got %b/%0d expected 1/7", done_valid, done_iid); end
    step();
  endtask

  task automatic test_back_to_back();
    addr(8'd1, 4'd1);
    step();
    addr(8'd0, 4'd2);
    #1;
    tests_run++; if (imm !== 9'd0) begin tests_failed++; $display("FAIL b2b_imm_nonempty: got %0d expected 0", imm); end
    step();
    idle();
    beat(1'b0);
    step();
    tests_run++; if (done_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_partial: got %b expected 0", done_valid); end
    beat(1'b1);
    addr(8'd0, 4'd3);
    #1;
    tests_run++; if (waddr_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_push_pop_ready: got %b expected 1", waddr_ready); end
    step();
    idle();
    tests_run++; if (done_valid !== 1'b1 || done_iid !== 4'd1) begin tests_failed++; $display("FAIL b2b_done_1: got %b/%0d expected 1/1", done_valid, done_iid); end
    beat(1'b1);
    step();
    tests_run++; if (done_valid !== 1'b1 || done_iid !== 4'd2) begin tests_failed++; $display("FAIL b2b_done_2: got %b/%0d expected 1/2", done_valid, done_iid); end
    step();
    idle();
    tests_run++; if (done_valid !== 1'b1 || done_iid !== 4'd3) begin tests_failed++; $display("FAIL b2b_done_3: got %b/%0d expected 1/3", done_valid, done_iid); end
    step();
    tests_run++; if (done_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: got %b expected 0", done_valid); end
    tests_run++; if (err_last !== 1'b0) begin tests_failed++; $display("FAIL b2b_err: got %b expected 0", err_last); end
  endtask

  task automatic test_limits();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      beat(1'b0);
      #1;
      tests_run++; if (s_wdata_ready !== (k <= 4)) begin tests_failed++; $display("FAIL limit_early beat %0d: got %b expected %b", k, s_wdata_ready, (k <= 4)); end
      step();
    end
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      addr(8'd0, 4'(k));
      #1;
      tests_run++; if (s_waddr_ready !== (k <= 2)) begin tests_failed++; $display("FAIL limit_queue_ready addr %0d: got %b expected %b", k, s_waddr_ready, (k <= 2)); end
      tests_run++; if (s_core_waddr_valid !== (k <= 2)) begin tests_failed++; $display("FAIL limit_queue_valid addr %0d: got %b expected %b", k, s_core_waddr_valid, (k <= 2)); end
      step();
    end
    do_reset();
  endtask

  task automatic test_err();
    addr(8'd1, 4'd1);
    step();
    idle();
    beat(1'b1);
    step();
    tests_run++; if (err_last !== 1'b1) begin tests_failed++; $display("FAIL err_early_last: got %b expected 1", err_last); end
    beat(1'b0);
    step();
    idle();
    tests_run++; if (done_valid !== 1'b1 || done_iid !== 4'd1) begin tests_failed++; $display("FAIL err_done: got %b/%0d expected 1/1", done_valid, done_iid); end
    step();
    step();
    tests_run++; if (err_last !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b expected 1", err_last); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (err_last !== 1'b0) begin tests_failed++; $display("FAIL err_reset: got %b expected 0", err_last); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    addr(8'd3, 4'd10);
    step();
    addr(8'd3, 4'd11);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    tests_run++; if (done_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_in_reset: got %b expected 0", done_valid); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if (done_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_after_release %0d: got %b expected 0", i, done_valid); end
    end
    addr(8'd1, 4'd9);
    #1;
    tests_run++; if (imm !== 9'd0 || core_waddr_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_new_addr: got imm %0d valid %b expected 0/1", imm, core_waddr_valid); end
    step();
    idle();
    beat(1'b0);
    step();
    tests_run++; if (done_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_partial: got %b expected 0", done_valid); end
    beat(1'b1);
    step();
    idle();
    tests_run++; if (done_valid !== 1'b1 || done_iid !== 4'd9) begin tests_failed++; $display("FAIL mid_done: got %b/%0d expected 1/9", done_valid, done_iid); end
    tests_run++; if (err_last !== 1'b0) begin tests_failed++; $display("FAIL mid_err: got %b expected 0", err_last); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early();
    test_same_cycle();
    test_back_to_back();
    test_limits();
    test_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
